// File: rtl/cordic_periph_ctrl.sv
// TinyQV register front end for the CORDIC core: latches an angle, starts the core, captures the result, with a timeout abort.
// Reads return one cycle after the request; an ANGLE write while busy is dropped and flagged as overrun.
module cordic_periph_ctrl #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [5:0]  address,
  input  logic [31:0] data_in,
  input  logic [1:0]  data_write_n,
  input  logic [1:0]  data_read_n,
  output logic [31:0] data_out,
  output logic        data_ready,
  output logic        user_interrupt,
  output logic [31:0] core_dataa,
  output logic        core_cos,
  output logic        core_start,
  output logic        core_clk_en,
  output logic        core_reset,
  input  logic        core_done,
  input  logic [31:0] core_result
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, START, WAIT, ABORT} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic          cos_sel, irq_en, irq_pend, err, ovr, valid;
  logic [31:0]   result;
  logic [31:0]   rd_mux;
  logic          wr_any, wr_word, rd_req;
  logic          angle_wr, ctrl_wr, result_rd, busy;
  logic          launch, capture, timeout;
  logic          unused_bits;

  assign wr_any    = (data_write_n != 2'b11);
  assign wr_word   = (data_write_n == 2'b10);
  assign rd_req    = (data_read_n != 2'b11);
  assign angle_wr  = wr_word && (address[3:2] == 2'd0);
  assign ctrl_wr   = wr_any && (address[3:2] == 2'd1);
  assign result_rd = rd_req && (address[3:2] == 2'd3);
  assign busy      = (state != IDLE);
  assign unused_bits = ^{address[5:4], address[1:0]};

  assign core_clk_en    = rst_n;
  assign core_reset     = !rst_n || (state == ABORT);
  assign user_interrupt = irq_pend & irq_en;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    core_start = 1'b0;
    launch     = 1'b0;
    capture    = 1'b0;
    timeout    = 1'b0;
    unique case (state)
      IDLE: begin
        if (angle_wr) begin
          launch    = 1'b1;
          state_nxt = START;
        end
      end
      START: begin
        core_start = 1'b1;
        state_nxt  = WAIT;
      end
      WAIT: begin
        if (core_done) begin
          capture   = 1'b1;
          state_nxt = IDLE;
        end else if (cnt >= CNT_LAST) begin
          timeout   = 1'b1;
          state_nxt = ABORT;
        end
      end
      ABORT:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Watchdog counter saturates instead of wrapping.
  always_ff @(posedge clk) begin
    if (!rst_n)                               cnt <= '0;
    else if (state == START)                  cnt <= '0;
    else if (state == WAIT && cnt != {CW{1'b1}}) cnt <= cnt + 1'b1;
  end

  always_comb begin
    rd_mux = 32'd0;
    case (address[3:2])
      2'd0: rd_mux = core_dataa;
      2'd1: rd_mux = {30'd0, irq_en, cos_sel};
      2'd2: rd_mux = {27'd0, ovr, err, irq_pend, valid, busy};
      2'd3: rd_mux = result;
      default: rd_mux = 32'd0;
    endcase
  end

  // Clears are applied before sets so a same-cycle event takes priority.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cos_sel    <= 1'b0;
      irq_en     <= 1'b0;
      irq_pend   <= 1'b0;
      err        <= 1'b0;
      ovr        <= 1'b0;
      valid      <= 1'b0;
      result     <= 32'd0;
      core_dataa <= 32'd0;
      core_cos   <= 1'b0;
      data_out   <= 32'd0;
      data_ready <= 1'b0;
    end else begin
      data_ready <= rd_req;
      data_out   <= rd_req ? rd_mux : 32'd0;
      if (ctrl_wr) begin
        cos_sel <= data_in[0];
        irq_en  <= data_in[1];
        if (data_in[2]) begin
          irq_pend <= 1'b0;
          err      <= 1'b0;
          ovr      <= 1'b0;
        end
      end
      if (launch) begin
        core_dataa <= data_in;
        core_cos   <= cos_sel;
      end
      if (angle_wr && busy) ovr <= 1'b1;
      if (result_rd || state == START) valid <= 1'b0;
      if (capture) begin
        result <= core_result;
        valid  <= 1'b1;
        if (irq_en) irq_pend <= 1'b1;
      end
      if (timeout) begin
        err <= 1'b1;
        if (irq_en) irq_pend <= 1'b1;
      end
    end
  end

endmodule

// File: doc/cordic_periph_ctrl.md
Name: cordic_periph_ctrl

Overview:
- Register front end between the TinyQV peripheral bus and the CORDIC instruction core (angle in, sin/cos result out).
- Latches a float32 angle written by software, issues a one-cycle start to the core and waits for its done.
- Captures and holds the result, exposes busy/valid/error status, and raises an optional interrupt.
- Bounds every operation with a timeout watchdog that aborts and resets the core.

Parameters:
- TIMEOUT_CYCLES, 64, number of WAIT cycles without core_done before the operation is aborted (≥8).

Ports:
- clk  in  1  single clock.
- rst_n  in  1  synchronous, active-low reset.
- address  in  6  byte address; only bits [3:2] are decoded.
- data_in  in  32  write data.
- data_write_n  in  2  11 = none, 00 = byte, 01 = half, 10 = word.
- data_read_n  in  2  11 = none, otherwise read request.
- data_out  out  32  read data, valid while data_ready = 1.
- data_ready  out  1  one-cycle read-complete strobe.
- user_interrupt  out  1  level interrupt.
- core_dataa  out  32  float32 angle to core.
- core_cos  out  1  1 = cosine, 0 = sine.
- core_start  out  1  one-cycle start pulse.
- core_clk_en  out  1  core clock enable.
- core_reset  out  1  active-high core reset.
- core_done  in  1  core result-valid strobe.
- core_result  in  32  float32 result from core.

Behaviour:
- Register map (word offsets):
  - 0x0 ANGLE: W, R returns last angle.
  - 0x4 CTRL: bit0 COS, bit1 IRQ_EN; bit2 write-1 clears IRQ_PEND, ERR and OVR, reads 0.
  - 0x8 STATUS: RO, bit0 BUSY, bit1 VALID, bit2 IRQ_PEND, bit3 ERR (timeout), bit4 OVR (overrun).
  - 0xC RESULT: RO; a read clears VALID.
- Reset (rst_n = 0 at clk edge):
  - All registers, data_out, core_dataa, core_cos, core_start, data_ready and user_interrupt go to 0.
  - core_reset = 1; core_clk_en = 0; FSM enters IDLE.
  - Reset mid-operation discards the operation; no result or interrupt follows.
- core_reset = 1 while rst_n = 0 and for exactly one cycle on timeout abort; 0 otherwise.
- core_clk_en = 1 whenever rst_n = 1.
- Writes:
  - CTRL accepts any width; only data_in[2:0] is used.
  - ANGLE accepts word writes only; byte and half writes are ignored.
  - An ANGLE word write while BUSY is ignored and sets OVR.
- FSM:
  - IDLE: an ANGLE word write latches core_dataa = data_in and core_cos = COS at that cycle, then goes to START.
  - START: core_start = 1 for this cycle only; BUSY = 1; VALID cleared; timeout counter cleared. Next state WAIT.
  - WAIT:
    - The counter increments each cycle.
    - If core_done = 1: RESULT <= core_result, VALID = 1, IRQ_PEND = 1 when IRQ_EN, go to IDLE.
    - Else if the counter reaches TIMEOUT_CYCLES - 1: ERR = 1, IRQ_PEND = 1 when IRQ_EN, go to ABORT.
  - ABORT: core_reset = 1 for one cycle; RESULT unchanged; then IDLE.
  - BUSY = 1 in START, WAIT and ABORT.
  - Counter width is $clog2(TIMEOUT_CYCLES+1); it saturates and never wraps.
  - core_done outside WAIT is ignored.
- Minimum latency: ANGLE write at cycle N, core_start high at N+1, earliest capture at N+2.
- Reads:
  - A request at cycle N produces data_ready = 1 and data_out at N+1, with the value sampled at N.
  - data_out = 0 when no read is in progress.
  - A RESULT read clears VALID at N+1.
  - If core_done capture and a RESULT read occur in the same cycle, the capture wins: VALID = 1 and the read returns the old RESULT.
- user_interrupt = IRQ_PEND & IRQ_EN.
- Simultaneous CTRL clear and IRQ set in the same cycle: the set wins.
- Write and read in the same cycle are both serviced.

Test Plan:
- Reset: hold rst_n = 0 for 3 cycles -> core_reset = 1, every output and every register reads 0, core_clk_en = 0.
- Cosine op: CTRL = 0x3, ANGLE = 0x3F800000; bench core asserts done after 20 cycles with 0x3F0A5140 -> core_start is one cycle at N+1 with core_cos = 1; STATUS = 0x06 then user_interrupt = 1; RESULT read returns 0x3F0A5140 and STATUS bit1 then reads 0.
- Overrun: write ANGLE 0x40000000 while BUSY -> core_dataa unchanged, OVR = 1; a CTRL write of 0x4 clears OVR.
- Timeout: TIMEOUT_CYCLES = 64, core never asserts done -> ABORT after 64 WAIT cycles, core_reset pulses 1 cycle, STATUS = 0x0C with IRQ_EN set, RESULT unchanged.
- Partial writes: byte write 0xFF to ANGLE -> no start, ANGLE unchanged; byte write 0x01 to CTRL -> COS = 1.
- Boundaries:
  - core_done coinciding with a RESULT read -> VALID stays 1.
  - rst_n low mid-WAIT followed by a late core_done -> no VALID and no interrupt.
